// File: rtl/cpu_multicycle.sv
// cpu_multicycle: 16-register multi-cycle CPU with a FETCH/DECODE/EXEC/MEM/HALT
// controller and req/ack instruction and data ports.
// Optional feature: define CPU_ILLEGAL_TRAP_EN so that opcode E raises trap and
// halts the core. Without it, opcode E is a NOP and trap is tied low.
module cpu_multicycle #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk_main,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic              trap,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
`ifdef CPU_ILLEGAL_TRAP_EN
  localparam logic [3:0] OP_RSVD = 4'hE;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic [DATA_W-1:0] rf_q [16];
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] br_off;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic              trap_q, trap_d;
`endif

  // Fixed instruction fields.
  logic [3:0] op, dr, sa, sb;
  logic [7:0] imm8;
  assign op   = ir_q[15:12];
  assign dr   = ir_q[11:8];
  assign sa   = ir_q[7:4];
  assign sb   = ir_q[3:0];
  assign imm8 = ir_q[7:0];

  // Branch offset: imm8 sign-extended (or truncated) to the PC width.
  assign br_off = ADDR_W'($signed(imm8));

  // ALU result for register-writing opcodes, computed from the latched operands
  // so a destination that is also a source sees its pre-instruction value.
  always_comb begin
    case (op)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SHL:  alu_res = a_q << 1;
      OP_SHR:  alu_res = a_q >> 1;
      OP_LDI:  alu_res = DATA_W'(imm8);
      default: alu_res = '0;
    endcase
  end

  // Next-state and datapath control for the multi-cycle controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    a_d      = a_q;
    b_d      = b_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
`ifdef CPU_ILLEGAL_TRAP_EN
    trap_d   = trap_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[sa];
        b_d     = rf_q[sb];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            rf_we = 1'b1;
            z_d   = (alu_res == '0);
          end
          OP_LDI: rf_we = 1'b1;
          OP_LD: begin
            dwe_d   = 1'b0;
            daddr_d = a_q[ADDR_W-1:0];
            state_d = S_MEM;
          end
          OP_ST: begin
            dwe_d    = 1'b1;
            daddr_d  = a_q[ADDR_W-1:0];
            dwdata_d = b_q;
            state_d  = S_MEM;
          end
          OP_BZ:   if (z_q) pc_d = pc_q + br_off;
          OP_JMP:  pc_d = a_q[ADDR_W-1:0];
          OP_HALT: state_d = S_HALT;
`ifdef CPU_ILLEGAL_TRAP_EN
          OP_RSVD: begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (!dwe_q) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          state_d = S_FETCH;
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural and control state, cleared asynchronously by reset.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      z_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      // NOTE: the register file must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
`ifdef CPU_ILLEGAL_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      if (rf_we) rf_q[dr] <= rf_wdata;
`ifdef CPU_ILLEGAL_TRAP_EN
      trap_q   <= trap_d;
`endif
    end
  end

  // Requests are pure state decodes; the fetch request is also gated by reset so it drops immediately.
  assign imem_req   = reset && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign halted     = (state_q == S_HALT);
  assign dbg_pc     = pc_q;
  assign dbg_state  = state_q;
`ifdef CPU_ILLEGAL_TRAP_EN
  assign trap       = trap_q;
`else
  assign trap       = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed sequences plus a randomized instruction stream,
// checked against an instruction-level model of the ISA kept in the bench.
module tb_cpu_multicycle;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DMASK  = (1 << DATA_W) - 1;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic              clk_main = 1'b0;
  logic              reset    = 1'b0;
  logic              imem_req, imem_ack = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata = '0;
  logic              dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata = '0;
  logic              halted, trap;
  logic [ADDR_W-1:0] dbg_pc;
  logic [2:0]        dbg_state;

  always #5 clk_main = ~clk_main;

  cpu_multicycle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_main(clk_main), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .trap(trap), .dbg_pc(dbg_pc), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ISA-level model state.
  int m_r [16];
  int m_z, m_pc;
  bit m_halt, m_trap;
  bit x_mem, x_we;
  int x_addr, x_wdata, x_ldreg;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_z = 0; m_pc = 0; m_halt = 0; m_trap = 0;
  endtask

  // Applies one instruction with plain integer arithmetic.
  task automatic model_exec(input logic [15:0] ins);
    int op, dr, a, b, imm, res;
    op  = int'(ins[15:12]);
    dr  = int'(ins[11:8]);
    a   = m_r[ins[7:4]];
    b   = m_r[ins[3:0]];
    imm = int'(ins[7:0]);
    x_mem = 0;
    m_pc = (m_pc + 1) & AMASK;
    res = 0;
    case (op)
      1: res = (a + b) & DMASK;
      2: res = (a - b) & DMASK;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = (~a) & DMASK;
      7: res = (a * 2) & DMASK;
      8: res = a / 2;
      default: ;
    endcase
    if (op >= 1 && op <= 8) begin
      m_r[dr] = res;
      m_z = (res == 0) ? 1 : 0;
    end
    case (op)
      9:  m_r[dr] = imm & DMASK;
      10: begin x_mem = 1; x_we = 0; x_addr = a & AMASK; x_ldreg = dr; end
      11: begin x_mem = 1; x_we = 1; x_addr = a & AMASK; x_wdata = b; end
      12: if (m_z != 0) m_pc = (m_pc + ((imm >= 128) ? imm - 256 : imm)) & AMASK;
      13: m_pc = a & AMASK;
`ifdef CPU_ILLEGAL_TRAP_EN
      14: begin m_halt = 1; m_trap = 1; end
`endif
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  // Waits for a fetch, checks its address, acks after iwait cycles.
  task automatic fetch_instr(input logic [15:0] ins, input int iwait);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk_main); n++; end
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, m_pc);
    check("req_excl", imem_req & dmem_req, 0);
    for (int i = 0; i < iwait; i++) begin
      @(negedge clk_main);
      check("fetch_hold", {imem_req, imem_addr}, {1'b1, ADDR_W'(m_pc)});
    end
    imem_ack = 1'b1; imem_rdata = ins;
    @(negedge clk_main);
    imem_ack = 1'b0; imem_rdata = 16'($urandom);
  endtask

  // Full instruction: fetch, data phase if any, then wait for next fetch.
  // lat counts cycles from the fetch ack to the next fetch request.
  task automatic do_instr(input logic [15:0] ins, input int iwait, input int dwait,
                          input logic [DATA_W-1:0] ldv, output int lat, output int dcyc);
    int n;
    fetch_instr(ins, iwait);
    model_exec(ins);
    n = 1; lat = -1; dcyc = 0;
    if (x_mem) begin
      while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk_main); n++; end
      check("dmem_req", dmem_req, 1);
      check("dmem_we", dmem_we, x_we);
      check("dmem_addr", dmem_addr, x_addr);
      if (x_we) check("dmem_wdata", dmem_wdata, x_wdata);
      check("req_excl", imem_req & dmem_req, 0);
      dcyc = 1;
      for (int i = 0; i < dwait; i++) begin
        @(negedge clk_main); n++;
        if (dmem_req === 1'b1) dcyc++;
        check("dmem_hold_addr", dmem_addr, x_addr);
        if (x_we) check("dmem_hold_wdata", dmem_wdata, x_wdata);
      end
      dmem_ack = 1'b1; dmem_rdata = ldv;
      @(negedge clk_main); n++;
      dmem_ack = 1'b0; dmem_rdata = DATA_W'($urandom);
      if (!x_we) m_r[x_ldreg] = int'(ldv);
    end
    if (!m_halt) begin
      while (imem_req !== 1'b1 && n < 20) begin @(negedge clk_main); n++; end
      lat = n;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
`ifdef CPU_ILLEGAL_TRAP_EN
    op = 4'($urandom_range(0, 13));
`else
    op = 4'($urandom_range(0, 14));
`endif
    if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(10, 11));
    return {op, 4'($urandom), 4'($urandom), 4'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, dcyc, n;
    // Reset values.
    #12;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_outs", {dmem_we, dmem_addr, dmem_wdata}, 0);
    check("rst_status", {halted, trap, dbg_pc, dbg_state}, 0);
    @(negedge clk_main); reset = 1'b1; #1;
    check("rel_imem_req", imem_req, 1);
    check("rel_imem_addr", imem_addr, 0);
    model_reset();

    // LDI/LDI/ADD with zero-wait acks: 3 cycles per instruction.
    do_instr(16'h9105, 0, 0, '0, lat, dcyc); check("lat_ldi", lat, 3);
    do_instr(16'h9203, 0, 0, '0, lat, dcyc);
    do_instr(16'h1312, 0, 0, '0, lat, dcyc); check("lat_add", lat, 3);
    // SUB R4,R1,R1 then BZ +2 at PC 4: taken to 7.
    do_instr(16'h2411, 0, 0, '0, lat, dcyc);
    do_instr(16'hC002, 0, 0, '0, lat, dcyc); check("bz_taken", imem_addr, 7);
    do_instr(16'hB013, 0, 0, '0, lat, dcyc); check("lat_st", lat, 4);
    do_instr(16'h9603, 0, 0, '0, lat, dcyc);
    do_instr(16'hD060, 0, 0, '0, lat, dcyc); check("jmp", imem_addr, 3);
    // SUB gives 2, Z=0: BZ falls through to 5.
    do_instr(16'h2412, 1, 0, '0, lat, dcyc);
    do_instr(16'hC002, 0, 0, '0, lat, dcyc); check("bz_not_taken", imem_addr, 5);
    // ST with ack delayed 3 cycles: request held 4 cycles.
    do_instr(16'hB012, 0, 3, '0, lat, dcyc);
    check("st_req_cycles", dcyc, 4); check("lat_st_wait", lat, 7);
    do_instr(16'hA510, 0, 0, 16'd3, lat, dcyc);
    do_instr(16'hB015, 0, 0, '0, lat, dcyc);
    // Data wrap: 0xFFFF + 1 = 0, Z=1, then BZ taken from 13 to 17.
    do_instr(16'h9700, 0, 0, '0, lat, dcyc);
    do_instr(16'h6870, 0, 0, '0, lat, dcyc);
    do_instr(16'h9901, 0, 0, '0, lat, dcyc);
    do_instr(16'h1A89, 0, 0, '0, lat, dcyc);
    do_instr(16'hB0A8, 0, 0, '0, lat, dcyc);
    do_instr(16'hC003, 0, 0, '0, lat, dcyc); check("wrap_bz", imem_addr, 17);
    // PC wrap: NOP at the top address falls through to 0.
    do_instr(16'h9B3F, 0, 0, '0, lat, dcyc);
    do_instr(16'hD0B0, 0, 0, '0, lat, dcyc); check("jmp_top", imem_addr, 63);
    do_instr(16'h0000, 0, 0, '0, lat, dcyc); check("pc_wrap", imem_addr, 0);

    // Randomized stream with random wait states.
    for (int k = 0; k < 300; k++)
      do_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
               DATA_W'($urandom), lat, dcyc);
    // Expose every register through a store.
    for (int r = 0; r < 16; r++)
      do_instr({4'hB, 4'h0, 4'(r), 4'(r)}, 0, 0, '0, lat, dcyc);

    // Reset during a data wait drops the request at once and clears registers.
    do_instr(16'h9105, 0, 0, '0, lat, dcyc);
    fetch_instr(16'hB012, 0);
    model_exec(16'hB012);
    n = 0;
    while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk_main); n++; end
    check("mid_dreq", dmem_req, 1);
    @(negedge clk_main);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dreq", dmem_req, 0);
    check("mid_rst_ireq", imem_req, 0);
    check("mid_rst_status", {halted, trap, dbg_pc, dbg_state}, 0);
    check("mid_rst_douts", {dmem_we, dmem_addr, dmem_wdata}, 0);
    @(negedge clk_main); reset = 1'b1; #1;
    check("mid_rel_ireq", imem_req, 1);
    check("mid_rel_addr", imem_addr, 0);
    model_reset();
    for (int r = 0; r < 16; r++)
      do_instr({4'hB, 4'(r), 4'(r), 4'(r)}, 0, 0, '0, lat, dcyc);

    // Opcode E.
    do_instr(16'hE123, 0, 0, '0, lat, dcyc);
`ifdef CPU_ILLEGAL_TRAP_EN
    repeat (2) @(negedge clk_main);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_main);
      check("trap_state", {trap, halted, imem_req}, 3'b110);
    end
    @(negedge clk_main); reset = 1'b0;
    @(negedge clk_main); reset = 1'b1;
    model_reset();
`else
    check("e_nop_trap", trap, 0);
    check("e_nop_next", imem_addr, m_pc);
`endif

    // HALT is terminal; acks while no request is pending are ignored.
    do_instr(16'h0000, 0, 0, '0, lat, dcyc);
    do_instr(16'hF000, 0, 0, '0, lat, dcyc);
    repeat (2) @(negedge clk_main);
    check("halt_flag", halted, 1);
    check("halt_state", dbg_state, 4);
    imem_ack = 1'b1; imem_rdata = 16'h0000; dmem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_main);
      check("halt_reqs", {imem_req, dmem_req}, 2'b00);
      check("halt_pc", dbg_pc, m_pc);
      check("halt_stays", {halted, dbg_state}, {1'b1, 3'd4});
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
